// File: rtl/flush_ctrl.sv
// Branch-mispredict recovery sequencer sitting in front of the ROB flush port.
// It picks the oldest mispredict from the two integer pipes and issues a
// one-cycle flush/redirect. Dispatch stays stalled while the ROB rolls back and
// walks. An older mispredict arriving mid-recovery preempts the current one.
module flush_ctrl #(
  parameter int ROB_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 br0_valid,
  input  logic [ROB_WIDTH:0]   br0_robid,
  input  logic [31:0]          br0_target,
  input  logic                 br1_valid,
  input  logic [ROB_WIDTH:0]   br1_robid,
  input  logic [31:0]          br1_target,
  input  logic [ROB_WIDTH:0]   rob_tail,
  input  logic [1:0]           rob_state,
  output logic                 flush_valid,
  output logic [ROB_WIDTH:0]   flush_robid,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 dispatch_stall,
  output logic                 recovery_err,
  output logic [15:0]          flush_count
);

  localparam int RW = ROB_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLUSH     = 2'd1,
    WAIT_RB   = 2'd2,
    WAIT_WALK = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] active_robid;
  logic [31:0]   active_pc;
  logic [TW-1:0] timer;
  logic          flush_q;
  logic          stall_q;

  logic [RW-1:0] age0;
  logic [RW-1:0] age1;
  logic [RW-1:0] active_age;
  logic [RW-1:0] cand_age;
  logic [RW-1:0] cand_robid;
  logic [31:0]   cand_pc;
  logic          cand_valid;
  logic          cand_older;
  logic          latch;
  logic          in_wait;
  logic          stay_wait;
  logic [TW:0]   wait_cnt;

  // Ages relative to the retire pointer; modular subtraction handles wrap.
  assign age0       = br0_robid - rob_tail;
  assign age1       = br1_robid - rob_tail;
  assign active_age = active_robid - rob_tail;

  // Pick the older valid report; on a tie pipe0 wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cand_robid = br0_robid;
    cand_pc    = br0_target;
    cand_age   = age0;
    if (br1_valid && (!br0_valid || (age1 < age0))) begin
      cand_robid = br1_robid;
      cand_pc    = br1_target;
      cand_age   = age1;
    end
  end

  assign cand_valid = br0_valid | br1_valid;
  assign cand_older = cand_valid && (cand_age < active_age);

  // Next-state logic: an older candidate always restarts the flush.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (cand_valid) begin
          latch     = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (cand_older) begin
          latch     = 1'b1;
          state_nxt = FLUSH;
        end else begin
          state_nxt = WAIT_RB;
        end
      end
      WAIT_RB: begin
        if (cand_older) begin
          latch     = 1'b1;
          state_nxt = FLUSH;
        end else if (rob_state == 2'b01) begin
          state_nxt = WAIT_WALK;
        end
      end
      WAIT_WALK: begin
        if (cand_older) begin
          latch     = 1'b1;
          state_nxt = FLUSH;
        end else if (rob_state == 2'b00) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_wait   = (state == WAIT_RB) || (state == WAIT_WALK);
  assign stay_wait = (state_nxt == WAIT_RB) || (state_nxt == WAIT_WALK);
  assign wait_cnt  = {1'b0, timer} + (TW+1)'(1);

  // State, latched flush target, registered outputs, timer and counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      state        <= IDLE;
      active_robid <= '0;
      active_pc    <= '0;
      timer        <= '0;
      flush_q      <= 1'b0;
      stall_q      <= 1'b0;
      recovery_err <= 1'b0;
      flush_count  <= '0;
    end else begin
      state   <= state_nxt;
      flush_q <= (state_nxt == FLUSH);
      stall_q <= (state_nxt != IDLE);
      if (latch) begin
        active_robid <= cand_robid;
        active_pc    <= cand_pc;
      end
      if ((state == FLUSH) && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
      if (in_wait && stay_wait)
        timer <= (wait_cnt >= (TW+1)'(TIMEOUT_CYC)) ? TW'(TIMEOUT_CYC) : wait_cnt[TW-1:0];
      else
        timer <= '0;
      if (in_wait && (wait_cnt >= (TW+1)'(TIMEOUT_CYC)))
        recovery_err <= 1'b1;
    end
  end

  assign flush_valid    = flush_q;
  assign redirect_valid = flush_q;
  assign flush_robid    = active_robid;
  assign redirect_pc    = active_pc;
  assign dispatch_stall = stall_q;

endmodule

// File: tb/tb_flush_ctrl.sv
// Testbench for flush_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural recovery model.
module tb_flush_ctrl;

  localparam int ROB_WIDTH = 4;
  localparam int RW        = ROB_WIDTH + 1;
  localparam int MODV      = 1 << RW;
  localparam int TIMEOUT   = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          br0_valid, br1_valid;
  logic [RW-1:0] br0_robid, br1_robid, rob_tail;
  logic [31:0]   br0_target, br1_target;
  logic [1:0]    rob_state;
  logic          flush_valid, redirect_valid, dispatch_stall, recovery_err;
  logic [RW-1:0] flush_robid;
  logic [31:0]   redirect_pc;
  logic [15:0]   flush_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model of the recovery
  bit            m_busy    = 1'b0;  // recovery in progress (dispatch blocked)
  bit            m_issue   = 1'b0;  // a flush is being presented this cycle
  bit            m_rb_seen = 1'b0;  // ROB has entered rollback for the current flush
  logic [RW-1:0] m_robid   = '0;
  logic [31:0]   m_pc      = '0;
  int            m_wait    = 0;
  bit            m_err     = 1'b0;
  int            m_count   = 0;

  flush_ctrl #(.ROB_WIDTH(ROB_WIDTH), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .br0_valid     (br0_valid),
    .br0_robid     (br0_robid),
    .br0_target    (br0_target),
    .br1_valid     (br1_valid),
    .br1_robid     (br1_robid),
    .br1_target    (br1_target),
    .rob_tail      (rob_tail),
    .rob_state     (rob_state),
    .flush_valid   (flush_valid),
    .flush_robid   (flush_robid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dispatch_stall(dispatch_stall),
    .recovery_err  (recovery_err),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int age(input logic [RW-1:0] r, input logic [RW-1:0] t);
    return ((int'(r) - int'(t)) % MODV + MODV) % MODV;
  endfunction

  // Model update: same sampling instant as the DUT, computed from the rules.
  always @(posedge clk) begin : model
    bit            take;
    logic [RW-1:0] c_id;
    logic [31:0]   c_pc;
    int            cyc;
    if (!reset_n) begin
      m_busy = 0; m_issue = 0; m_rb_seen = 0; m_robid = '0; m_pc = '0;
      m_wait = 0; m_err = 0; m_count = 0;
    end else begin
      take = 0;
      c_id = br0_robid;
      c_pc = br0_target;
      if (br0_valid || br1_valid) begin
        if (!(br0_valid && (!br1_valid || age(br0_robid, rob_tail) <= age(br1_robid, rob_tail)))) begin
          c_id = br1_robid;
          c_pc = br1_target;
        end
        take = !m_busy || (age(c_id, rob_tail) < age(m_robid, rob_tail));
      end
      if (m_issue && m_count < 65535) m_count++;
      cyc = 0;
      if (m_busy && !m_issue) begin
        cyc = m_wait + 1;
        if (cyc >= TIMEOUT) m_err = 1;
      end
      if (take) begin
        m_robid = c_id; m_pc = c_pc; m_issue = 1; m_busy = 1; m_wait = 0; m_rb_seen = 0;
      end else if (m_issue) begin
        m_issue = 0; m_wait = 0; m_rb_seen = 0;
      end else if (m_busy) begin
        if (!m_rb_seen) begin
          if (rob_state == 2'b01) m_rb_seen = 1;
        end else if (rob_state == 2'b00) begin
          m_busy = 0;
        end
        m_wait = m_busy ? ((cyc > TIMEOUT) ? TIMEOUT : cyc) : 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_flush_valid",    64'(flush_valid),    64'(m_issue));
      check("cmp_redirect_valid", 64'(redirect_valid), 64'(m_issue));
      check("cmp_flush_robid",    64'(flush_robid),    64'(m_robid));
      check("cmp_redirect_pc",    64'(redirect_pc),    64'(m_pc));
      check("cmp_dispatch_stall", 64'(dispatch_stall), 64'(m_busy));
      check("cmp_recovery_err",   64'(recovery_err),   64'(m_err));
      check("cmp_flush_count",    64'(flush_count),    64'(m_count));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_br();
    br0_valid = 0;
    br1_valid = 0;
  endtask

  // From WAIT_RB: rollback, walk, then idle; stall drops after the last tick.
  task automatic finish_from_wait();
    rob_state = 2'b01; tick();
    rob_state = 2'b10; tick();
    rob_state = 2'b00; tick();
  endtask

  initial begin
    reset_n = 0; clear_br();
    br0_robid = '0; br1_robid = '0; br0_target = '0; br1_target = '0;
    rob_tail = '0; rob_state = 2'b00;
    tick(); tick();
    cmp_en = 1;
    check("reset_flush_valid", 64'(flush_valid), 64'd0);
    check("reset_stall",       64'(dispatch_stall), 64'd0);
    check("reset_count",       64'(flush_count), 64'd0);
    reset_n = 1;

    // 1: single mispredict, full recovery
    rob_tail = 5'd2;
    br0_valid = 1; br0_robid = 5'd5; br0_target = 32'h0000_1000;
    tick();
    check("t1_flush_valid", 64'(flush_valid), 64'd1);
    check("t1_redirect",    64'(redirect_valid), 64'd1);
    check("t1_robid",       64'(flush_robid), 64'd5);
    check("t1_pc",          64'(redirect_pc), 64'h1000);
    check("t1_stall",       64'(dispatch_stall), 64'd1);
    clear_br(); tick();
    check("t1_flush_drop",  64'(flush_valid), 64'd0);
    rob_state = 2'b01; tick();
    rob_state = 2'b10; tick(); tick();
    check("t1_stall_walk",  64'(dispatch_stall), 64'd1);
    rob_state = 2'b00; tick();
    check("t1_stall_off",   64'(dispatch_stall), 64'd0);
    check("t1_count",       64'(flush_count), 64'd1);

    // 2: both pipes, pipe1 older
    br0_valid = 1; br0_robid = 5'd9; br0_target = 32'hAAAA_0000;
    br1_valid = 1; br1_robid = 5'd4; br1_target = 32'hBBBB_0000;
    tick();
    check("t2_robid", 64'(flush_robid), 64'd4);
    check("t2_pc",    64'(redirect_pc), 64'hBBBB_0000);
    clear_br(); tick(); finish_from_wait();
    check("t2_count", 64'(flush_count), 64'd2);

    // 3: wrap-around age selection
    rob_tail = 5'h1E;
    br0_valid = 1; br0_robid = 5'h01; br0_target = 32'h0000_0100;
    br1_valid = 1; br1_robid = 5'h1F; br1_target = 32'h0000_01F0;
    tick();
    check("t3_robid", 64'(flush_robid), 64'h1F);
    check("t3_pc",    64'(redirect_pc), 64'h1F0);
    clear_br(); tick(); finish_from_wait();

    // 4: preemption in WAIT_WALK, then a younger report is dropped
    rob_tail = 5'd0;
    br0_valid = 1; br0_robid = 5'd7; br0_target = 32'h0000_7000;
    tick();
    clear_br(); rob_state = 2'b01; tick(); tick();
    rob_state = 2'b10; tick();
    br1_valid = 1; br1_robid = 5'd3; br1_target = 32'h0000_3000;
    tick();
    check("t4_preempt_valid", 64'(flush_valid), 64'd1);
    check("t4_preempt_robid", 64'(flush_robid), 64'd3);
    check("t4_preempt_pc",    64'(redirect_pc), 64'h3000);
    clear_br(); tick();
    br0_valid = 1; br0_robid = 5'd6; br0_target = 32'h0000_6000;
    tick();
    check("t4_drop_valid", 64'(flush_valid), 64'd0);
    check("t4_drop_robid", 64'(flush_robid), 64'd3);
    clear_br(); finish_from_wait();
    check("t4_count", 64'(flush_count), 64'd5);

    // 5: ROB stuck in walk -> sticky error, stall held
    br0_valid = 1; br0_robid = 5'd2; br0_target = 32'h0000_2000;
    tick();
    clear_br(); tick();
    rob_state = 2'b01; tick();
    rob_state = 2'b10;
    repeat (TIMEOUT - 2) tick();
    check("t5_err_before", 64'(recovery_err), 64'd0);
    tick();
    check("t5_err",   64'(recovery_err), 64'd1);
    check("t5_stall", 64'(dispatch_stall), 64'd1);
    rob_state = 2'b00; tick();

    // 6: reset during WAIT_RB
    br0_valid = 1; br0_robid = 5'd4; br0_target = 32'h0000_4000;
    tick();
    clear_br(); tick();
    reset_n = 0; tick();
    check("t6_flush",  64'(flush_valid), 64'd0);
    check("t6_stall",  64'(dispatch_stall), 64'd0);
    check("t6_err",    64'(recovery_err), 64'd0);
    check("t6_count",  64'(flush_count), 64'd0);
    check("t6_robid",  64'(flush_robid), 64'd0);
    check("t6_pc",     64'(redirect_pc), 64'd0);
    reset_n = 1; tick();
    check("t6_no_reissue", 64'(flush_valid), 64'd0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      br0_valid  = ($urandom_range(0, 7) == 0);
      br0_robid  = RW'($urandom);
      br0_target = $urandom;
      br1_valid  = ($urandom_range(0, 7) == 0);
      br1_robid  = ($urandom_range(0, 7) == 0) ? br0_robid : RW'($urandom);
      br1_target = $urandom;
      r = $urandom_range(0, 9);
      rob_state  = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 15) == 0) rob_tail = RW'($urandom);
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    clear_br(); reset_n = 1; tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
